// File: rtl/alpha_blender_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alpha_blender_pkg
// Purpose  : Shared types and constants for the alpha blender slice.
//            rgb888_t    - packed {R[23:16], G[15:8], B[7:0]} pixel
//            colour_e    - 3-bit foreground colour code {R,G,B}
//            ALPHA_ONE   - full weight (4 quarters)
//            WEIGHT_W    - width of a stored weight (0..4)
//            cfg_legal() - legality test for a settings capture
// Revision : 1.0 - initial release
// ============================================================================
package alpha_blender_pkg;

    localparam int CH_W     = 8;
    localparam int SUM_W    = 10;
    localparam int WEIGHT_W = 3;

    localparam logic [WEIGHT_W-1:0] ALPHA_ONE = 3'd4;

    typedef logic [3*CH_W-1:0] rgb888_t;

    typedef enum logic [2:0] {
        BLACK = 3'd0,
        BLUE  = 3'd1,
        GREEN = 3'd2,
        RED   = 3'd4,
        WHITE = 3'd7
    } colour_e;

    // Weights must each be in range and together make exactly one unit.
    function automatic logic cfg_legal(input logic [3:0] t, input logic [3:0] c);
        logic [4:0] w_total;
        w_total = {1'b0, t} + {1'b0, c};
        return (t <= 4'd4) && (w_total == 5'd4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/blend_channel.sv
`default_nettype none
// ============================================================================
// Module   : blend_channel
// Purpose  : One 8-bit colour channel of the blender, two register stages.
//            Stage 1 holds fg*a and bg*c, stage 2 holds the scaled sum.
//            Macro ALPHA_BLENDER_ROUND_EN: round-to-nearest instead of
//            truncation on the final divide by four.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            i_s1_en       - load stage 1
//            i_s2_en       - load stage 2
//            i_fg_on       - foreground colour bit for this channel
//            i_bg          - background channel value
//            i_a, i_c      - foreground / background weights (quarters)
//            o_pix         - blended channel value (stage 2 register)
// Revision : 1.0 - initial release
// ============================================================================
module blend_channel
    import alpha_blender_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_s1_en,
    input  logic                i_s2_en,
    input  logic                i_fg_on,
    input  logic [CH_W-1:0]     i_bg,
    input  logic [WEIGHT_W-1:0] i_a,
    input  logic [WEIGHT_W-1:0] i_c,
    output logic [CH_W-1:0]     o_pix
);

    logic [SUM_W-1:0] w_fg_prod;
    logic [SUM_W-1:0] w_bg_prod;
    logic [SUM_W-1:0] w_sum;
    logic [CH_W-1:0]  w_out;
    logic [SUM_W-1:0] r_fg_prod;
    logic [SUM_W-1:0] r_bg_prod;
    logic [CH_W-1:0]  r_pix;

    // Weights never exceed 4, so each product fits in 10 bits (max 1020).
    assign w_fg_prod = (i_fg_on ? SUM_W'(8'hFF) : '0) * SUM_W'(i_a);
    assign w_bg_prod = SUM_W'(i_bg) * SUM_W'(i_c);
    assign w_sum     = r_fg_prod + r_bg_prod;

`ifdef ALPHA_BLENDER_ROUND_EN
    // Largest sum is 1020, so adding the half-LSB cannot overflow 10 bits.
    assign w_out = CH_W'((w_sum + SUM_W'(2)) >> 2);
`else
    assign w_out = CH_W'(w_sum >> 2);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fg_prod <= '0;
            r_bg_prod <= '0;
            r_pix     <= '0;
        end else begin
            if (i_s1_en) begin
                r_fg_prod <= w_fg_prod;
                r_bg_prod <= w_bg_prod;
            end
            if (i_s2_en) begin
                r_pix <= w_out;
            end
        end
    end

    assign o_pix = r_pix;

endmodule
`default_nettype wire

// File: rtl/alpha_blender.sv
`default_nettype none
// ============================================================================
// Module   : alpha_blender
// Purpose  : Blends a solid foreground colour over an RGB888 background
//            stream with quarter-step weights. Settings are sampled only
//            on the first pixel of a frame. Two-stage valid/ready pipeline.
//            Macro ALPHA_BLENDER_ROUND_EN: rounded output (latency same).
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            color                    - foreground colour code {R,G,B}
//            transparency             - foreground weight, quarters
//            transparency_complement  - background weight, quarters
//            in_valid/in_ready/in_sof/in_pixel    - background stream
//            out_valid/out_ready/out_sof/out_pixel - blended stream
//            cfg_err                  - latched settings were illegal
// Revision : 1.0 - initial release
// ============================================================================
module alpha_blender
    import alpha_blender_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  color,
    input  logic [3:0]  transparency,
    input  logic [3:0]  transparency_complement,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sof,
    input  rgb888_t     in_pixel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output rgb888_t     out_pixel,
    output logic        cfg_err
);

    logic                r_s1_valid;
    logic                r_s1_sof;
    logic                r_s2_valid;
    logic                r_s2_sof;
    logic [2:0]          r_color;
    logic [WEIGHT_W-1:0] r_a;
    logic [WEIGHT_W-1:0] r_c;
    logic                r_cfg_err;

    logic                w_s1_en;
    logic                w_s2_en;
    logic                w_in_fire;
    logic                w_capture;
    logic                w_legal;
    logic [WEIGHT_W-1:0] w_new_a;
    logic [WEIGHT_W-1:0] w_new_c;
    logic [2:0]          w_color_eff;
    logic [WEIGHT_W-1:0] w_a_eff;
    logic [WEIGHT_W-1:0] w_c_eff;

    // A stage loads when it is empty or its contents move on this cycle.
    assign w_s2_en   = !r_s2_valid || out_ready;
    assign w_s1_en   = !r_s1_valid || w_s2_en;
    assign in_ready  = w_s1_en;
    assign w_in_fire = in_valid && w_s1_en;
    assign w_capture = w_in_fire && in_sof;

    assign w_legal = cfg_legal(transparency, transparency_complement);
    assign w_new_a = w_legal ? transparency[WEIGHT_W-1:0]            : ALPHA_ONE;
    assign w_new_c = w_legal ? transparency_complement[WEIGHT_W-1:0] : '0;

    // The capturing pixel itself already uses the new settings; weights are
    // applied at stage-1 entry, so pixels already in flight keep theirs.
    assign w_color_eff = w_capture ? color   : r_color;
    assign w_a_eff     = w_capture ? w_new_a : r_a;
    assign w_c_eff     = w_capture ? w_new_c : r_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_sof   <= 1'b0;
            r_color    <= BLACK;
            r_a        <= '0;
            r_c        <= ALPHA_ONE;
            r_cfg_err  <= 1'b0;
        end else begin
            if (w_s1_en) begin
                r_s1_valid <= in_valid;
                r_s1_sof   <= in_valid && in_sof;
            end
            if (w_s2_en) begin
                r_s2_valid <= r_s1_valid;
                r_s2_sof   <= r_s1_valid && r_s1_sof;
            end
            if (w_capture) begin
                r_color   <= color;
                r_a       <= w_new_a;
                r_c       <= w_new_c;
                r_cfg_err <= !w_legal;
            end
        end
    end

    // Channel 0 is blue (colour bit 0, pixel bits 7:0), up to red.
    for (genvar gi = 0; gi < 3; gi++) begin : g_channel
        blend_channel u_blend_channel (
            .clk     (clk),
            .rst     (rst),
            .i_s1_en (w_s1_en),
            .i_s2_en (w_s2_en),
            .i_fg_on (w_color_eff[gi]),
            .i_bg    (in_pixel[CH_W*gi +: CH_W]),
            .i_a     (w_a_eff),
            .i_c     (w_c_eff),
            .o_pix   (out_pixel[CH_W*gi +: CH_W])
        );
    end

    assign out_valid = r_s2_valid;
    assign out_sof   = r_s2_sof;
    assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_alpha_blender.sv
`default_nettype none
// ============================================================================
// Module   : tb_alpha_blender
// Purpose  : Directed self-checking bench for alpha_blender. Inputs change
//            1 time unit after a rising edge; outputs are checked there too.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alpha_blender;

    logic        clk;
    logic        rst;
    logic [2:0]  color;
    logic [3:0]  transparency;
    logic [3:0]  transparency_complement;
    logic        in_valid;
    logic        in_ready;
    logic        in_sof;
    logic [23:0] in_pixel;
    logic        out_valid;
    logic        out_ready;
    logic        out_sof;
    logic [23:0] out_pixel;
    logic        cfg_err;

    int checks   = 0;
    int failures = 0;

    alpha_blender dut (
        .clk                     (clk),
        .rst                     (rst),
        .color                   (color),
        .transparency            (transparency),
        .transparency_complement (transparency_complement),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .in_sof                  (in_sof),
        .in_pixel                (in_pixel),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .out_sof                 (out_sof),
        .out_pixel               (out_pixel),
        .cfg_err                 (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one pixel for a single transfer cycle, then go idle.
    task automatic send(input logic sof, input logic [2:0] col, input logic [3:0] t,
                        input logic [3:0] c, input logic [23:0] pix);
        in_valid                = 1'b1;
        in_sof                  = sof;
        color                   = col;
        transparency            = t;
        transparency_complement = c;
        in_pixel                = pix;
        step();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    logic [23:0] bp_pix [3];
    logic [23:0] exp_red;
    int          accepted;
    int          idx;
    logic        was_ready;

    initial begin
        rst = 1'b1; color = 3'd0; transparency = 4'd0; transparency_complement = 4'd0;
        in_valid = 1'b0; in_sof = 1'b0; in_pixel = 24'h0; out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sof",   32'(out_sof),   32'd0);
        check("rst_out_pixel", 32'(out_pixel), 32'h0);
        check("rst_cfg_err",   32'(cfg_err),   32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        // Pass-through before any frame start, two-cycle latency
        send(1'b0, 3'd7, 4'd4, 4'd0, 24'h123456);
        check("pt_lat1_valid", 32'(out_valid), 32'd0);
        step();
        check("pt_valid",   32'(out_valid), 32'd1);
        check("pt_pixel",   32'(out_pixel), 32'h123456);
        check("pt_sof",     32'(out_sof),   32'd0);
        check("pt_cfg_err", 32'(cfg_err),   32'd0);
        step();

        // Red at half weight over blue
`ifdef ALPHA_BLENDER_ROUND_EN
        exp_red = 24'h800080;
`else
        exp_red = 24'h7F007F;
`endif
        send(1'b1, 3'd4, 4'd2, 4'd2, 24'h0000FF);
        check("red_cfg_err", 32'(cfg_err), 32'd0);
        step();
        check("red_pixel", 32'(out_pixel), 32'(exp_red));
        check("red_sof",   32'(out_sof),   32'd1);
        step();

        // Green at 3/4; colour change without frame start is ignored
        send(1'b1, 3'd2, 4'd3, 4'd1, 24'h404040);
        in_valid = 1'b1; in_sof = 1'b0; color = 3'd1; in_pixel = 24'h404040;
        step();
        check("green_pixel", 32'(out_pixel), 32'h10CF10);
        check("green_sof",   32'(out_sof),   32'd1);
        in_valid = 1'b0;
        step();
        check("green_hold_valid", 32'(out_valid), 32'd1);
        check("green_hold_pixel", 32'(out_pixel), 32'h10CF10);
        check("green_hold_sof",   32'(out_sof),   32'd0);
        step();

        // Illegal transparency > 4 falls back to full foreground
        send(1'b1, 3'd1, 4'd5, 4'd0, 24'hFFFFFF);
        check("ill_t_cfg_err", 32'(cfg_err), 32'd1);
        step();
        check("ill_t_pixel", 32'(out_pixel), 32'h0000FF);
        step();

        // Illegal weight sum (2+1) also falls back
        send(1'b1, 3'd7, 4'd2, 4'd1, 24'h000000);
        check("ill_sum_cfg_err", 32'(cfg_err), 32'd1);
        step();
        check("ill_sum_pixel", 32'(out_pixel), 32'hFFFFFF);
        step();

        // Legal pass-through capture clears the error
        send(1'b1, 3'd7, 4'd0, 4'd4, 24'hABCDEF);
        check("legal_cfg_err", 32'(cfg_err), 32'd0);
        step();
        check("legal_pixel", 32'(out_pixel), 32'hABCDEF);
        step();

        // Backpressure: six stalled cycles, only two pixels fit
        bp_pix[0] = 24'h010203; bp_pix[1] = 24'h040506; bp_pix[2] = 24'h070809;
        out_ready = 1'b0; in_valid = 1'b1; in_sof = 1'b0;
        idx = 0; accepted = 0; in_pixel = bp_pix[0];
        for (int k = 0; k < 6; k++) begin
            was_ready = in_ready;
            step();
            if (was_ready) begin
                accepted++;
                if (idx < 2) idx++;
                in_pixel = bp_pix[idx];
            end
            if (k >= 1) begin
                check("bp_stall_valid", 32'(out_valid), 32'd1);
                check("bp_stall_pixel", 32'(out_pixel), 32'(bp_pix[0]));
            end
        end
        check("bp_accepted", 32'(accepted), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        check("bp_rel1_pixel", 32'(out_pixel), 32'(bp_pix[1]));
        in_valid = 1'b0;
        step();
        check("bp_rel2_valid", 32'(out_valid), 32'd1);
        check("bp_rel2_pixel", 32'(out_pixel), 32'(bp_pix[2]));
        step();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Reset with two pixels in flight
        send(1'b1, 3'd7, 4'd4, 4'd0, 24'h000000);
        step();
        check("white_pixel", 32'(out_pixel), 32'hFFFFFF);
        step();
        in_valid = 1'b1; in_sof = 1'b0; in_pixel = 24'h111111;
        step();
        in_pixel = 24'h222222;
        step();
        check("fl_valid", 32'(out_valid), 32'd1);
        rst = 1'b1; in_pixel = 24'h333333;
        step();
        check("fl_rst_valid", 32'(out_valid), 32'd0);
        check("fl_rst_pixel", 32'(out_pixel), 32'h0);
        rst = 1'b0; in_valid = 1'b0;
        check("fl_rst_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("fl_no_emit", 32'(out_valid), 32'd0);
        end
        send(1'b0, 3'd7, 4'd4, 4'd0, 24'h5A5A5A);
        step();
        check("fl_pt_pixel",   32'(out_pixel), 32'h5A5A5A);
        check("fl_pt_cfg_err", 32'(cfg_err),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
